brs_req_scheduler: RTL and testbench

BRS_REQ_SCHEDULER -- requirements
Module: brs_req_scheduler

---
 rtl/brs_pkg.sv | 17 +
 rtl/brs_req_scheduler_if.sv | 25 ++
 rtl/brs_lead1_enc.sv | 23 ++
 rtl/brs_req_scheduler.sv | 118 +++++++++++
 tb/tb_brs_req_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/brs_pkg.sv
// Shared types and constants for the request scheduler: requester count,
// index width and the FSM state encoding.
package brs_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } brs_state_e;

    localparam brs_state_e IDLE_CODE = ST_IDLE;

endpackage

// File: rtl/brs_req_scheduler_if.sv
// Requester/resource bundle for the scheduler. Grant handshake: a grant is
// offered while gnt_valid=1 and completes on the first rising edge where gnt_ack=1.
interface brs_req_scheduler_if;
    import brs_pkg::*;

    logic             ena;
    logic [N_REQ-1:0] req;
    logic             gnt_ack;
    logic             err_clr;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_id;
    logic [N_REQ-1:0] pend;
    logic             err;

    modport master (
        output ena, req, gnt_ack, err_clr,
        input  gnt_valid, gnt_id, pend, err
    );

    modport slave (
        input  ena, req, gnt_ack, err_clr,
        output gnt_valid, gnt_id, pend, err
    );

endinterface

// File: rtl/brs_lead1_enc.sv
// Combinational leading-one encoder: index of the highest set bit and a
// flag telling whether any bit was set at all.
module brs_lead1_enc
    import brs_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/brs_req_scheduler.sv
// Descending round-robin request scheduler: latches request pulses into a
// pending register and issues one acknowledged (or timed-out) grant at a time.
module brs_req_scheduler #(
    parameter int N_REQ   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    brs_req_scheduler_if.slave          bus,
    output brs_pkg::brs_state_e         state_o
);
    import brs_pkg::*;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    brs_state_e       state_q;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] k_q;
    logic [IDX_W-1:0] gnt_id_q;
    logic [7:0]       cnt_q;
    logic             gnt_valid_q;
    logic             err_q;

    logic [N_REQ-1:0] below_k;
    logic [IDX_W-1:0] idx_masked, idx_full, winner;
    logic             vld_masked, vld_full;

    // Bits strictly below the last winner are searched first; k=0 masks everything.
    assign below_k = (N_REQ'(1) << k_q) - N_REQ'(1);

    brs_lead1_enc u_enc_masked (
        .vec_i   (pend_q & below_k),
        .idx_o   (idx_masked),
        .valid_o (vld_masked)
    );

    brs_lead1_enc u_enc_full (
        .vec_i   (pend_q),
        .idx_o   (idx_full),
        .valid_o (vld_full)
    );

    always_comb begin
        winner = k_q;
        if (vld_masked) begin
            winner = idx_masked;
        end else if (vld_full) begin
            winner = idx_full;
        end
    end

    // Winner's bit drops on the ARB->GRANT edge unless re-requested in that same cycle.
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_ARB) begin
            pend_d[winner] = 1'b0;
        end
        pend_d = pend_d | bus.req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.ena && (pend_q != '0)) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    state_q     <= ST_GRANT;
                    k_q         <= winner;
                    gnt_id_q    <= winner;
                    gnt_valid_q <= 1'b1;
                    cnt_q       <= '0;
                end
                ST_GRANT: begin
                    // Ack beats a coinciding timeout; a timeout beats err_clr.
                    if (bus.gnt_ack || (cnt_q == TMO_LAST)) begin
                        state_q     <= ST_RELEASE;
                        gnt_valid_q <= 1'b0;
                        gnt_id_q    <= '0;
                        cnt_q       <= '0;
                        if (!bus.gnt_ack) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.pend      = pend_q;
    assign bus.err       = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_brs_req_scheduler.sv
// Directed bench for brs_req_scheduler: reset, round-robin order, timeout,
// re-request, enable gating and reset during a grant.
module tb_brs_req_scheduler;
    import brs_pkg::*;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst;
    brs_state_e state_o;
    int         n_cmp = 0;
    int         n_fail = 0;

    brs_req_scheduler_if bus ();

    brs_req_scheduler #(.N_REQ(16), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_grant(input int max_cyc, output int cyc);
        cyc = 0;
        while (bus.gnt_valid !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_reset();
        bus.ena = 1'b1; bus.req = '0; bus.gnt_ack = 1'b0; bus.err_clr = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.ena = 1'b1; bus.req = '0; bus.gnt_ack = 1'b0; bus.err_clr = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_valid: got %b want 0", bus.gnt_valid); end
        n_cmp++; if (bus.gnt_id !== 4'h0) begin n_fail++; $display("FAIL reset_gnt_id: got %h want 0", bus.gnt_id); end
        n_cmp++; if (bus.pend !== 16'h0000) begin n_fail++; $display("FAIL reset_pend: got %h want 0000", bus.pend); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
        n_cmp++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE); end
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL reset_idle_hold: got %0d want %0d", state_o, ST_IDLE); end
    endtask

    task automatic test_basic();
        int cyc;
        do_reset();
        bus.req = 16'h8001; tick(); bus.req = '0;
        n_cmp++; if (bus.pend !== 16'h8001) begin n_fail++; $display("FAIL basic_pend: got %h want 8001", bus.pend); end
        wait_grant(8, cyc);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", cyc); end
        n_cmp++; if (bus.gnt_id !== 4'd15) begin n_fail++; $display("FAIL basic_first_id: got %0d want 15", bus.gnt_id); end
        n_cmp++; if (bus.pend !== 16'h0001) begin n_fail++; $display("FAIL basic_pend_after_win: got %h want 0001", bus.pend); end
        bus.gnt_ack = 1'b1; tick(); bus.gnt_ack = 1'b0;
        n_cmp++; if (bus.gnt_valid !== 1'b0 || bus.gnt_id !== 4'h0) begin n_fail++; $display("FAIL basic_release: got valid=%b id=%0d want 0/0", bus.gnt_valid, bus.gnt_id); end
        n_cmp++; if (state_o !== ST_RELEASE) begin n_fail++; $display("FAIL basic_release_state: got %0d want %0d", state_o, ST_RELEASE); end
        wait_grant(8, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL basic_second_latency: got %0d want 3", cyc); end
        n_cmp++; if (bus.gnt_id !== 4'd0) begin n_fail++; $display("FAIL basic_second_id: got %0d want 0", bus.gnt_id); end
        n_cmp++; if (bus.pend !== 16'h0000) begin n_fail++; $display("FAIL basic_pend_empty: got %h want 0000", bus.pend); end
        bus.gnt_ack = 1'b1; tick(); bus.gnt_ack = 1'b0;
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", bus.err); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [3:0] exp_id;
        do_reset();
        bus.req = 16'hFFFF;
        wait_grant(8, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 3", cyc); end
        for (int g = 0; g < 17; g++) begin
            exp_id = 4'(15 - (g % 16));
            n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== exp_id) begin n_fail++; $display("FAIL b2b_id[%0d]: got valid=%b id=%0d want 1/%0d", g, bus.gnt_valid, bus.gnt_id, exp_id); end
            n_cmp++; if (bus.pend !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_pend[%0d]: got %h want ffff", g, bus.pend); end
            bus.gnt_ack = 1'b1; tick(); bus.gnt_ack = 1'b0;
            if (g < 16) begin
                wait_grant(8, cyc);
                n_cmp++; if (cyc + 1 !== 4) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", g, cyc + 1); end
            end
        end
        bus.req = '0;
    endtask

    task automatic test_timeout();
        int cyc;
        int n;
        do_reset();
        bus.gnt_ack = 1'b1; bus.req = 16'h0010; tick(); bus.req = '0; bus.gnt_ack = 1'b0;
        wait_grant(8, cyc);
        n_cmp++; if (bus.gnt_id !== 4'd4) begin n_fail++; $display("FAIL tmo_id: got %0d want 4", bus.gnt_id); end
        n = 0;
        while (bus.gnt_valid === 1'b1 && n < TMO + 4) begin
            n++;
            tick();
        end
        n_cmp++; if (n !== TMO) begin n_fail++; $display("FAIL tmo_duration: got %0d want %0d", n, TMO); end
        n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %b want 1", bus.err); end
        n_cmp++; if (bus.pend !== 16'h0000) begin n_fail++; $display("FAIL tmo_pend: got %h want 0000", bus.pend); end
        n_cmp++; if (state_o !== ST_RELEASE) begin n_fail++; $display("FAIL tmo_state: got %0d want %0d", state_o, ST_RELEASE); end
        repeat (3) tick();
        n_cmp++; if (bus.gnt_valid !== 1'b0 || bus.err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got valid=%b err=%b want 0/1", bus.gnt_valid, bus.err); end
        bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clr: got %b want 0", bus.err); end
    endtask

    task automatic test_timeout_races();
        int cyc;
        do_reset();
        bus.req = 16'h0010; tick(); bus.req = '0;
        wait_grant(8, cyc);
        repeat (TMO - 1) tick();
        n_cmp++; if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL race_last_cycle_valid: got %b want 1", bus.gnt_valid); end
        bus.gnt_ack = 1'b1; tick(); bus.gnt_ack = 1'b0;
        n_cmp++; if (bus.gnt_valid !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL race_ack_wins: got valid=%b err=%b want 0/0", bus.gnt_valid, bus.err); end
        bus.req = 16'h0010; tick(); bus.req = '0;
        wait_grant(8, cyc);
        repeat (TMO - 1) tick();
        bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
        n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b want 1", bus.err); end
    endtask

    task automatic test_regrant();
        int cyc;
        do_reset();
        bus.req = 16'h0020; tick(); bus.req = '0;
        wait_grant(8, cyc);
        n_cmp++; if (bus.gnt_id !== 4'd5 || bus.pend !== 16'h0000) begin n_fail++; $display("FAIL regrant_first: got id=%0d pend=%h want 5/0000", bus.gnt_id, bus.pend); end
        tick();
        bus.req = 16'h0020; tick(); bus.req = '0;
        n_cmp++; if (bus.pend !== 16'h0020 || bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL regrant_pend: got pend=%h valid=%b want 0020/1", bus.pend, bus.gnt_valid); end
        bus.gnt_ack = 1'b1; tick(); bus.gnt_ack = 1'b0;
        wait_grant(8, cyc);
        n_cmp++; if (cyc !== 3 || bus.gnt_id !== 4'd5) begin n_fail++; $display("FAIL regrant_again: got cyc=%0d id=%0d want 3/5", cyc, bus.gnt_id); end
        n_cmp++; if (bus.pend !== 16'h0000) begin n_fail++; $display("FAIL regrant_pend_clear: got %h want 0000", bus.pend); end
        bus.gnt_ack = 1'b1; tick(); bus.gnt_ack = 1'b0;
    endtask

    task automatic test_ena();
        do_reset();
        bus.ena = 1'b0;
        bus.req = 16'h0003; tick(); bus.req = '0;
        repeat (4) tick();
        n_cmp++; if (bus.gnt_valid !== 1'b0 || state_o !== ST_IDLE) begin n_fail++; $display("FAIL ena_blocked: got valid=%b state=%0d want 0/%0d", bus.gnt_valid, state_o, ST_IDLE); end
        n_cmp++; if (bus.pend !== 16'h0003) begin n_fail++; $display("FAIL ena_pend_held: got %h want 0003", bus.pend); end
        bus.ena = 1'b1; tick();
        n_cmp++; if (state_o !== ST_ARB || bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL ena_arb: got state=%0d valid=%b want %0d/0", state_o, bus.gnt_valid, ST_ARB); end
        tick();
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 4'd1) begin n_fail++; $display("FAIL ena_grant: got valid=%b id=%0d want 1/1", bus.gnt_valid, bus.gnt_id); end
        bus.ena = 1'b0; tick();
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 4'd1) begin n_fail++; $display("FAIL ena_no_abort: got valid=%b id=%0d want 1/1", bus.gnt_valid, bus.gnt_id); end
        bus.gnt_ack = 1'b1; tick(); bus.gnt_ack = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.gnt_valid !== 1'b0 || state_o !== ST_IDLE || bus.pend !== 16'h0001) begin n_fail++; $display("FAIL ena_idle_after: got valid=%b state=%0d pend=%h want 0/%0d/0001", bus.gnt_valid, state_o, bus.pend, ST_IDLE); end
        bus.ena = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        do_reset();
        bus.req = 16'h0040; tick(); bus.req = '0;
        wait_grant(8, cyc);
        bus.req = 16'h0300; tick(); bus.req = '0;
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 4'd6 || bus.pend !== 16'h0300) begin n_fail++; $display("FAIL rstg_setup: got valid=%b id=%0d pend=%h want 1/6/0300", bus.gnt_valid, bus.gnt_id, bus.pend); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.gnt_valid !== 1'b0 || bus.gnt_id !== 4'h0) begin n_fail++; $display("FAIL rstg_grant_drop: got valid=%b id=%0d want 0/0", bus.gnt_valid, bus.gnt_id); end
        n_cmp++; if (bus.pend !== 16'h0000 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rstg_pend_err: got pend=%h err=%b want 0000/0", bus.pend, bus.err); end
        n_cmp++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL rstg_state: got %0d want %0d", state_o, ST_IDLE); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.gnt_valid !== 1'b0 || bus.pend !== 16'h0000) begin n_fail++; $display("FAIL rstg_after: got valid=%b pend=%h want 0/0000", bus.gnt_valid, bus.pend); end
    endtask

    initial begin
        rst = 1'b1;
        bus.ena = 1'b1; bus.req = '0; bus.gnt_ack = 1'b0; bus.err_clr = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_timeout_races();
        test_regrant();
        test_ena();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
